// File: rtl/wallace_mac_controller.sv
// Dot-product controller for an 8x8 Wallace tree multiplier (external, combinational).
// Ports: start/len cmd, in_valid/in_ready pairs, mul_a/mul_b/mul_p, out_valid/out_ready result, busy.
module wallace_mac_controller #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             s1_valid;
  logic             s2_valid;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             accept;
  logic [ACC_W:0]   sum;

  assign in_ready  = (state == ACCUM) && (remaining != '0);
  assign accept    = in_valid && in_ready;
  assign sum       = {1'b0, acc} + (ACC_W+1)'(prod);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      prod      <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      // stage 0: register operands toward the multiplier
      s1_valid <= accept;
      if (accept) begin
        mul_a     <= in_a;
        mul_b     <= in_b;
        remaining <= remaining - CNT_W'(1);
      end
      // stage 1: capture the multiplier product
      s2_valid <= s1_valid;
      if (s1_valid) begin
        prod <= mul_p;
      end
      // stage 2: accumulate, sticky carry-out
      if (s2_valid) begin
        acc <= sum[ACC_W-1:0];
        if (sum[ACC_W]) begin
          ovf <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
            state     <= (len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (accept && remaining == CNT_W'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // remaining is zero here, so an empty stage 1 means the
          // product being added this edge is the last one
          if (s2_valid && !s1_valid) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/wallace_mac_controller.md
WALLACE_MAC_CONTROLLER -- requirements
Module: wallace_mac_controller

Interface
REQ-001 SHALL provide parameter ACC_W, default 24, accumulator/result width; legal range 16..32.
REQ-002 SHALL provide parameter CNT_W, default 8, width of the pair-count field.
REQ-003 SHALL provide clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide start  input  1  request to begin a dot product, sampled only in IDLE.
REQ-006 SHALL provide len  input  CNT_W  number of operand pairs, captured with start.
REQ-007 SHALL provide in_valid  input  1  operand pair valid.
REQ-008 SHALL provide in_ready  output  1  controller accepts a pair this cycle.
REQ-009 SHALL provide in_a, in_b  input  8 each  unsigned operands.
REQ-010 SHALL provide mul_a, mul_b  output  8 each  registered operands driven to the 8-bit Wallace tree multiplier.
REQ-011 SHALL provide mul_p  input  16  combinational product returned by the multiplier (exact or approximate).
REQ-012 SHALL provide out_valid  output  1  result available.
REQ-013 SHALL provide out_ready  input  1  consumer takes result.
REQ-014 SHALL provide out_acc  output  ACC_W  accumulated sum.
REQ-015 SHALL provide out_ovf  output  1  sticky flag, accumulator carried out of ACC_W bits.
REQ-016 SHALL provide busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCUM, DRAIN, DONE.
REQ-018 IDLE: start=1 and len!=0 -> ACCUM; load remaining=len, clear acc and ovf.
REQ-019 IDLE: start=1 and len==0 -> DONE directly; acc=0, ovf=0.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 in_ready SHALL be 1 exactly when state==ACCUM and remaining!=0; 0 otherwise.
REQ-022 Accept = in_valid & in_ready at edge k: mul_a<=in_a, mul_b<=in_b, stage-1 valid set, remaining decremented.
REQ-023 At edge k+1 the controller SHALL capture mul_p into a 16-bit product register when stage-1 valid is set.
REQ-024 At edge k+2 acc SHALL become (acc + zero-extended product) mod 2^ACC_W; ovf SHALL be set if the addition carries out; ovf never clears except via REQ-018/019/reset.
REQ-025 Pipeline SHALL never stall; back-to-back accepts every cycle SHALL be supported (throughput 1 pair/cycle).
REQ-026 Gaps (in_valid=0) SHALL insert bubbles; bubbles SHALL not change acc.
REQ-027 ACCUM -> DRAIN on the edge accepting the last pair (remaining 1->0).
REQ-028 DRAIN -> DONE on the edge where the final product is added (edge k+2 of last accept); out_valid SHALL be visible in the cycle after that edge.
REQ-029 DONE: out_valid=1, out_acc=acc, out_ovf=ovf held stable until out_ready=1; on that edge -> IDLE.
REQ-030 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-031 mul_a/mul_b SHALL hold their last value when no accept occurs.
REQ-032 out_acc and out_ovf SHALL retain last values in IDLE until the next start clears them.

Reset
REQ-033 rst=1 SHALL immediately force state=IDLE, remaining=0, pipeline valids=0, mul_a=mul_b=0, product=0, acc=0, ovf=0; hence in_ready=0, out_valid=0, busy=0.
REQ-034 rst asserted mid-ACCUM/DRAIN/DONE SHALL abandon the operation; no out_valid until a new start after rst deasserts.

Verification
REQ-035 len=3, pairs (2,3),(4,5),(255,255) back-to-back, exact mul_p model -> out_acc=65051, out_ovf=0, out_valid 3 cycles after last accept edge +0 (per REQ-028).
REQ-036 len=2 with in_valid low 4 cycles between pairs (3,7),(10,10) -> out_acc=121; in_ready stays 1 during gap, drops after second accept.
REQ-037 ACC_W=16, len=2, pairs (255,255),(255,255) -> out_acc=0xFC02, out_ovf=1.
REQ-038 start with len=0 -> DONE next edge, out_acc=0, out_ovf=0, in_ready never asserts.
REQ-039 out_ready held 0 for 5 cycles in DONE, start pulsed meanwhile -> result held stable, start ignored, IDLE only after out_ready=1.
REQ-040 rst pulsed after 2 of 4 pairs accepted -> all outputs zero per REQ-033; subsequent start len=1 pair (6,7) -> out_acc=42.
